// File: rtl/lif_pkg.sv
// Shared defaults and helpers for the time-multiplexed LIF neuron array.
package lif_pkg;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_NUM_NEURONS = 4;
  localparam int unsigned DEF_BETA_SHIFT  = 1;
  localparam int unsigned DEF_REFRACT     = 2;

  // Refractory counter width; at least one bit even when refractory is disabled.
  function automatic int unsigned refr_w(input int unsigned refract);
    return (refract < 1) ? 1 : $clog2(refract + 1);
  endfunction

  // Unsigned add clamped to 2^w-1 (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] mx;
    s  = {1'b0, a} + {1'b0, b};
    mx = (33'(1) << w) - 33'(1);
    return (s > mx) ? 32'(mx) : 32'(s);
  endfunction

endpackage

// File: rtl/lif_array_tm_if.sv
// Current-injection handshake and update/spike event stream of the neuron array.
interface lif_array_tm_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic [WIDTH-1:0] in_current;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic [WIDTH-1:0] out_state;
  logic             out_spike;
  logic             frame_done;

  modport master (
    output in_valid, in_idx, in_current,
    input  in_ready, out_valid, out_idx, out_state, out_spike, frame_done
  );

  modport slave (
    input  in_valid, in_idx, in_current,
    output in_ready, out_valid, out_idx, out_state, out_spike, frame_done
  );
endinterface

// File: rtl/lif_update.sv
// Single-neuron leak/integrate/fire step, purely combinational.
module lif_update
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned BETA_SHIFT = DEF_BETA_SHIFT,
  parameter int unsigned REFRACT    = DEF_REFRACT,
  parameter int unsigned RW         = refr_w(DEF_REFRACT)
) (
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] cur,
  input  logic [RW-1:0]    refr,
  input  logic [WIDTH-1:0] threshold,
  output logic [WIDTH-1:0] next_state,
  output logic [RW-1:0]    next_refr,
  output logic             spike
);

  logic [WIDTH-1:0] sum;

  always_comb begin
    next_state = '0;
    next_refr  = refr;
    spike      = 1'b0;
    sum        = '0;
    if (refr != '0) begin
      // Refractory: input current is dropped and membrane held at zero.
      next_refr = refr - RW'(1);
    end else begin
      sum = WIDTH'(sat_add(32'(cur), 32'(state >> BETA_SHIFT), WIDTH));
      if (sum >= threshold) begin
        spike     = 1'b1;
        next_refr = RW'(REFRACT);
      end else begin
        next_state = sum;
      end
    end
  end

endmodule

// File: rtl/lif_array_tm.sv
// Time-multiplexed LIF neuron array: per-neuron storage, round-robin scheduler,
// single-slot current buffers and registered event output.
module lif_array_tm
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int unsigned BETA_SHIFT  = DEF_BETA_SHIFT,
  parameter int unsigned REFRACT     = DEF_REFRACT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     cfg_threshold,
  lif_array_tm_if.slave        bus
);

  localparam int unsigned IDX_W = $clog2(NUM_NEURONS);
  localparam int unsigned RW    = refr_w(REFRACT);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

  logic [WIDTH-1:0]       state_q [NUM_NEURONS];
  logic [WIDTH-1:0]       pend_q  [NUM_NEURONS];
  logic [RW-1:0]          refr_q  [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] flag_q;
  logic [IDX_W-1:0]       ptr_q;

  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt_state;
  logic [RW-1:0]    nxt_refr;
  logic             spike;
  logic             accept;

  always_comb begin
    cur = flag_q[ptr_q] ? pend_q[ptr_q] : '0;
  end

  // A busy slot frees up in the cycle its neuron is being consumed.
  assign bus.in_ready = !flag_q[bus.in_idx] | (en & (ptr_q == bus.in_idx));
  assign accept       = bus.in_valid & bus.in_ready;

  lif_update #(
    .WIDTH      (WIDTH),
    .BETA_SHIFT (BETA_SHIFT),
    .REFRACT    (REFRACT),
    .RW         (RW)
  ) u_update (
    .state      (state_q[ptr_q]),
    .cur        (cur),
    .refr       (refr_q[ptr_q]),
    .threshold  (cfg_threshold),
    .next_state (nxt_state),
    .next_refr  (nxt_refr),
    .spike      (spike)
  );

  // Neuron storage and scheduler; a same-neuron write lands after the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_NEURONS); i++) begin
        state_q[i] <= '0;
        pend_q[i]  <= '0;
        refr_q[i]  <= '0;
      end
      flag_q <= '0;
      ptr_q  <= '0;
    end else begin
      if (en) begin
        state_q[ptr_q] <= nxt_state;
        refr_q[ptr_q]  <= nxt_refr;
        flag_q[ptr_q]  <= 1'b0;
        ptr_q          <= (ptr_q == LAST) ? '0 : ptr_q + IDX_W'(1);
      end
      if (accept) begin
        pend_q[bus.in_idx] <= bus.in_current;
        flag_q[bus.in_idx] <= 1'b1;
      end
    end
  end

  // Event output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_idx    <= '0;
      bus.out_state  <= '0;
      bus.out_spike  <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.out_valid  <= en;
      bus.out_spike  <= en & spike;
      bus.frame_done <= en & (ptr_q == LAST);
      if (en) begin
        bus.out_idx   <= ptr_q;
        bus.out_state <= nxt_state;
      end
    end
  end

endmodule

// File: tb/tb_lif_array_tm.sv
// Directed bench for lif_array_tm with reference model and expected-event queue.
module tb_lif_array_tm;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] cfg_threshold;

  lif_array_tm_if #(.WIDTH(8), .IDX_W(2)) bus ();

  lif_array_tm dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .cfg_threshold (cfg_threshold),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] st;
    logic       sp;
    logic       fd;
  } exp_t;

  exp_t sbq[$];
  int   log_st[$];
  int   log_sp[$];
  int   idx_log[$];
  int   log_idx;
  int   n_valid;
  int   n_fd;
  logic last_ready;

  int m_state[4];
  int m_pend[4];
  int m_flag[4];
  int m_refr[4];
  int m_p;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int get_q(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_state[i] = 0; m_pend[i] = 0; m_flag[i] = 0; m_refr[i] = 0;
    end
    m_p = 0;
    sbq.delete();
    log_st.delete();
    log_sp.delete();
    idx_log.delete();
    n_valid = 0;
    n_fd    = 0;
  endtask

  // One clock: drive at posedge+1, check at negedge, advance model, end at posedge+1.
  task automatic cyc(input logic e, input logic v, input logic [1:0] idx, input logic [7:0] cv);
    exp_t ex;
    logic rdy_m;
    int   cur, s, ns, nr, sp;
    en = e; bus.in_valid = v; bus.in_idx = idx; bus.in_current = cv;
    @(negedge clk);
    rdy_m = (m_flag[idx] == 0) || (e && m_p == int'(idx));
    last_ready = bus.in_ready;
    chk("in_ready", 32'(bus.in_ready), 32'(rdy_m));
    if (sbq.size() > 0) begin
      ex = sbq.pop_front();
      chk("out_valid", 32'(bus.out_valid), 32'd1);
      chk("out_idx", 32'(bus.out_idx), 32'(ex.idx));
      chk("out_state", 32'(bus.out_state), 32'(ex.st));
      chk("out_spike", 32'(bus.out_spike), 32'(ex.sp));
      chk("frame_done", 32'(bus.frame_done), 32'(ex.fd));
      if (bus.out_valid) begin
        n_valid++;
        idx_log.push_back(int'(bus.out_idx));
        if (int'(bus.out_idx) == log_idx) begin
          log_st.push_back(int'(bus.out_state));
          log_sp.push_back(int'(bus.out_spike));
        end
      end
      if (bus.frame_done) n_fd++;
    end else begin
      chk("idle_valid", 32'(bus.out_valid), 32'd0);
      chk("idle_frame_done", 32'(bus.frame_done), 32'd0);
    end
    if (e) begin
      cur = (m_flag[m_p] != 0) ? m_pend[m_p] : 0;
      sp  = 0;
      if (m_refr[m_p] != 0) begin
        ns = 0; nr = m_refr[m_p] - 1;
      end else begin
        s = cur + (m_state[m_p] >> 1);
        if (s > 255) s = 255;
        if (s >= int'(cfg_threshold)) begin
          sp = 1; ns = 0; nr = 2;
        end else begin
          ns = s; nr = 0;
        end
      end
      ex.idx = 2'(m_p); ex.st = 8'(ns); ex.sp = sp[0]; ex.fd = (m_p == 3);
      sbq.push_back(ex);
      m_state[m_p] = ns; m_refr[m_p] = nr; m_flag[m_p] = 0;
      m_p = (m_p == 3) ? 0 : m_p + 1;
    end
    if (v && rdy_m) begin
      m_pend[idx] = int'(cv);
      m_flag[idx] = 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    en = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_state", 32'(bus.out_state), 32'd0);
    chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
    chk("rst_out_spike", 32'(bus.out_spike), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_threshold = 8'd127;
    bus.in_valid = 1'b0; bus.in_idx = '0; bus.in_current = '0;
    log_idx = -1;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-frame with pending writes; first update after release is neuron 0.
    cyc(1'b1, 1'b1, 2'd2, 8'd40);
    cyc(1'b1, 1'b1, 2'd3, 8'd90);
    cyc(1'b1, 1'b1, 2'd2, 8'd70);
    do_reset();
    log_idx = 0;
    cyc(1'b1, 1'b0, 2'd0, 8'd0);
    cyc(1'b0, 1'b0, 2'd0, 8'd0);
    chk("post_rst_first_idx", 32'(get_q(idx_log, 0)), 32'd0);
    chk("post_rst_first_state", 32'(get_q(log_st, 0)), 32'd0);

    // Single write decays by half every frame.
    do_reset();
    log_idx = 0;
    cyc(1'b0, 1'b1, 2'd0, 8'd100);
    repeat (20) cyc(1'b1, 1'b0, 2'd0, 8'd0);
    cyc(1'b0, 1'b0, 2'd0, 8'd0);
    chk("leak_f1", 32'(get_q(log_st, 0)), 32'd100);
    chk("leak_f2", 32'(get_q(log_st, 1)), 32'd50);
    chk("leak_f3", 32'(get_q(log_st, 2)), 32'd25);
    chk("leak_f4", 32'(get_q(log_st, 3)), 32'd12);
    chk("leak_f5", 32'(get_q(log_st, 4)), 32'd6);
    chk("leak_nospike", 32'(log_sp.sum()), 32'd0);

    // Spike, then refractory frames drop input.
    do_reset();
    log_idx = 0;
    cyc(1'b0, 1'b1, 2'd0, 8'd100);
    for (int f = 0; f < 5; f++)
      for (int k = 0; k < 4; k++)
        cyc(1'b1, (k == 1) && (f < 4), 2'd0, 8'd100);
    cyc(1'b0, 1'b0, 2'd0, 8'd0);
    chk("refr_st1", 32'(get_q(log_st, 0)), 32'd100);
    chk("refr_sp2", 32'(get_q(log_sp, 1)), 32'd1);
    chk("refr_st2", 32'(get_q(log_st, 1)), 32'd0);
    chk("refr_st3", 32'(get_q(log_st, 2)), 32'd0);
    chk("refr_sp3", 32'(get_q(log_sp, 2)), 32'd0);
    chk("refr_st4", 32'(get_q(log_st, 3)), 32'd0);
    chk("refr_st5", 32'(get_q(log_st, 4)), 32'd100);

    // Saturation: 255 + 100 clamps to 255 and reaches threshold 255.
    cfg_threshold = 8'd255;
    do_reset();
    log_idx = 0;
    cyc(1'b0, 1'b1, 2'd0, 8'd200);
    for (int k = 0; k < 8; k++) cyc(1'b1, k == 1, 2'd0, 8'd255);
    cyc(1'b0, 1'b0, 2'd0, 8'd0);
    chk("sat_st1", 32'(get_q(log_st, 0)), 32'd200);
    chk("sat_sp1", 32'(get_q(log_sp, 0)), 32'd0);
    chk("sat_sp2", 32'(get_q(log_sp, 1)), 32'd1);
    cfg_threshold = 8'd127;

    // Busy slot: in_ready low until the target neuron is being updated.
    do_reset();
    log_idx = 2;
    cyc(1'b1, 1'b1, 2'd2, 8'd40);
    chk("hs_first_ready", 32'(last_ready), 32'd1);
    cyc(1'b1, 1'b1, 2'd2, 8'd30);
    chk("hs_busy_ready", 32'(last_ready), 32'd0);
    cyc(1'b1, 1'b1, 2'd2, 8'd30);
    chk("hs_consume_ready", 32'(last_ready), 32'd1);
    repeat (5) cyc(1'b1, 1'b0, 2'd2, 8'd0);
    cyc(1'b0, 1'b0, 2'd0, 8'd0);
    chk("hs_st_f1", 32'(get_q(log_st, 0)), 32'd40);
    chk("hs_st_f2", 32'(get_q(log_st, 1)), 32'd50);

    // Enable gaps: pointer holds, no index skipped.
    do_reset();
    log_idx = -1;
    for (int i = 0; i < 16; i++) cyc((i % 4 == 0) || (i % 4 == 3), 1'b0, 2'd0, 8'd0);
    cyc(1'b0, 1'b0, 2'd0, 8'd0);
    chk("en_valid_count", 32'(n_valid), 32'd8);
    chk("en_fd_count", 32'(n_fd), 32'd2);
    for (int i = 0; i < 8; i++) chk("en_idx_seq", 32'(get_q(idx_log, i)), 32'(i % 4));

    // Zero threshold fires on every non-refractory update.
    cfg_threshold = 8'd0;
    do_reset();
    log_idx = 0;
    repeat (16) cyc(1'b1, 1'b0, 2'd0, 8'd0);
    cyc(1'b0, 1'b0, 2'd0, 8'd0);
    chk("thr0_sp1", 32'(get_q(log_sp, 0)), 32'd1);
    chk("thr0_sp2", 32'(get_q(log_sp, 1)), 32'd0);
    chk("thr0_sp3", 32'(get_q(log_sp, 2)), 32'd0);
    chk("thr0_sp4", 32'(get_q(log_sp, 3)), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
